// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: d = x - y - b_in, one bit per clock, LSB first.
// Operands are captured on an accepted start; d/b_out update only on completion.
module serial_subtractor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         b_out
);

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [W-1:0]  r_xs;
    logic [W-1:0]  r_ys;
    logic          r_br;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [W-1:0]  r_d;
    logic          r_b_out;

    logic          w_accept;
    logic          w_last;
    logic          w_diff;
    logic          w_br_next;
    logic [W-1:0]  w_result;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_last    = (r_state == RUN) && (r_cnt == LAST);
    assign w_diff    = r_xs[0] ^ r_ys[0] ^ r_br;
    assign w_br_next = (~r_xs[0] & r_ys[0]) | (~(r_xs[0] ^ r_ys[0]) & r_br);

    // The partial-result register holds only the W-1 bits finished before the
    // last step; the final bit is merged straight into d on completion.
    if (W == 1) begin : g_w1
        assign w_result = w_diff;
    end else begin : g_wn
        logic [W-2:0] r_acc;

        assign w_result = {w_diff, r_acc};

        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_result[W-1:1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path leaves the output unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == LAST) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xs    <= '0;
            r_ys    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_b_out <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_xs  <= x;
                r_ys  <= y;
                r_br  <= b_in;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_xs  <= r_xs >> 1;
                r_ys  <= r_ys >> 1;
                r_br  <= w_br_next;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_last) begin
                r_d     <= w_result;
                r_b_out <= w_br_next;
            end
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = r_done;
    assign d     = r_d;
    assign b_out = r_b_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive self-checking bench for serial_subtractor (W=4 and W=1).
module tb_serial_subtractor;

    logic       clk;
    logic       reset;

    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       b_out;

    logic       start1;
    logic       x1;
    logic       y1;
    logic       b_in1;
    logic       busy1;
    logic       done1;
    logic       d1;
    logic       b_out1;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .b_in(b_in),
        .busy(busy), .done(done), .d(d), .b_out(b_out)
    );

    serial_subtractor #(.W(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .x(x1), .y(y1), .b_in(b_in1),
        .busy(busy1), .done(done1), .d(d1), .b_out(b_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one W=4 operation; lat is the number of cycles after the accept
    // edge until done is seen (99 on timeout). Operands are scrambled mid-run.
    task automatic run_op4(input logic [3:0] ax, input logic [3:0] ay, input logic ab,
                           output logic [3:0] od, output logic ob, output int lat);
        @(negedge clk);
        x = ax; y = ay; b_in = ab; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 4'($urandom); y = 4'($urandom); b_in = 1'($urandom);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        od = d;
        ob = b_out;
    endtask

    task automatic run_op1(input logic ax, input logic ay, input logic ab,
                           output logic od, output logic ob, output int lat);
        @(negedge clk);
        x1 = ax; y1 = ay; b_in1 = ab; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        x1 = 1'($urandom); y1 = 1'($urandom); b_in1 = 1'($urandom);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                lat = n;
                break;
            end
        end
        od = d1;
        ob = b_out1;
    endtask

    task automatic test_reset();
        int spurious;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (d !== 4'b0000)  begin n_fail++; $display("FAIL reset_d: got %b want 0000", d); end
        n_checks++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL reset_b_out: got %b want 0", b_out); end
        n_checks++; if ({busy1, done1, d1, b_out1} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_w1: got %b want 0000", {busy1, done1, d1, b_out1}); end
        spurious = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", spurious); end
    endtask

    task automatic test_basic();
        logic [3:0] od;
        logic       ob;
        int         lat;
        run_op4(4'b0101, 4'b0011, 1'b0, od, ob, lat);
        n_checks++; if (lat !== 4)      begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_checks++; if (od !== 4'b0010) begin n_fail++; $display("FAIL basic_d: got %b want 0010", od); end
        n_checks++; if (ob !== 1'b0)    begin n_fail++; $display("FAIL basic_b_out: got %b want 0", ob); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_checks++; if (od !== d)       begin n_fail++; $display("FAIL basic_d_held: got %b want %b", d, od); end
    endtask

    task automatic test_borrow();
        // {x, y, b_in, expected d, expected b_out}
        logic [13:0] vec [3] = '{
            {4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1},
            {4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1},
            {4'b1111, 4'b0000, 1'b1, 4'b1110, 1'b0}
        };
        logic [3:0] od;
        logic       ob;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_op4(vec[i][13:10], vec[i][9:6], vec[i][5], od, ob, lat);
            n_checks++; if ({od, ob} !== vec[i][4:0])
                begin n_fail++; $display("FAIL borrow_%0d: got d=%b b_out=%b want d=%b b_out=%b", i, od, ob, vec[i][4:1], vec[i][0]); end
            n_checks++; if (lat !== 4)
                begin n_fail++; $display("FAIL borrow_%0d_latency: got %0d want 4", i, lat); end
        end
    endtask

    // start is held for 10 cycles; accepts land on the first cycle and on
    // the cycle after the first done, so dones appear at cycles 5 and 10.
    task automatic test_back_to_back();
        int pos[$];
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c > 0 && done === 1'b1) begin
                pos.push_back(c);
                n_checks++; if ({d, b_out} !== 5'b11111)
                    begin n_fail++; $display("FAIL b2b_result_c%0d: got d=%b b_out=%b want 1111 1", c, d, b_out); end
            end
            start = (c < 10);
            if (busy === 1'b0) {x, y, b_in} = {4'hf, 4'hf, 1'b1};
            else               {x, y, b_in} = 9'($urandom);
        end
        start = 1'b0;
        n_checks++; if (pos.size() !== 2)
            begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", pos.size()); end
        if (pos.size() == 2) begin
            n_checks++; if (pos[0] !== 5)  begin n_fail++; $display("FAIL b2b_first_done: got cycle %0d want 5", pos[0]); end
            n_checks++; if (pos[1] !== 10) begin n_fail++; $display("FAIL b2b_second_done: got cycle %0d want 10", pos[1]); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] od;
        logic       ob;
        int         lat;
        int         spurious;
        @(negedge clk);
        x = 4'b1001; y = 4'b0001; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if ({busy, done, d, b_out} !== 7'b0)
            begin n_fail++; $display("FAIL midreset_clear: got busy=%b done=%b d=%b b_out=%b want all 0", busy, done, d, b_out); end
        spurious = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        n_checks++; if (spurious !== 0)
            begin n_fail++; $display("FAIL midreset_no_done: got %0d done pulses want 0", spurious); end
        run_op4(4'b1001, 4'b0100, 1'b0, od, ob, lat);
        n_checks++; if ({od, ob, lat} !== {4'b0101, 1'b0, 32'd4})
            begin n_fail++; $display("FAIL midreset_fresh: got d=%b b_out=%b lat=%0d want 0101 0 4", od, ob, lat); end
    endtask

    task automatic test_exhaustive();
        logic [3:0] od;
        logic       ob;
        logic       od1;
        logic       ob1;
        logic [4:0] ev;
        logic [1:0] ev1;
        int         lat;
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    run_op4(4'(xi), 4'(yi), 1'(bi), od, ob, lat);
                    ev = 5'(xi - yi - bi);
                    n_checks++; if ({ob, od} !== ev)
                        begin n_fail++; $display("FAIL ex4 %0d-%0d-%0d: got %b want %b", xi, yi, bi, {ob, od}, ev); end
                    n_checks++; if (4'(od + 4'(yi) + 4'(bi)) !== 4'(xi))
                        begin n_fail++; $display("FAIL ex4_adder %0d-%0d-%0d: got %0d want %0d", xi, yi, bi, 4'(od + 4'(yi) + 4'(bi)), xi); end
                    n_checks++; if (lat !== 4)
                        begin n_fail++; $display("FAIL ex4_latency %0d-%0d-%0d: got %0d want 4", xi, yi, bi, lat); end
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            run_op1(1'(c >> 2), 1'(c >> 1), 1'(c), od1, ob1, lat);
            ev1 = 2'(((c >> 2) & 1) - ((c >> 1) & 1) - (c & 1));
            n_checks++; if ({ob1, od1} !== ev1)
                begin n_fail++; $display("FAIL ex1 combo%0d: got %b want %b", c, {ob1, od1}, ev1); end
            n_checks++; if (1'(od1 + 1'(c >> 1) + 1'(c)) !== 1'(c >> 2))
                begin n_fail++; $display("FAIL ex1_adder combo%0d: got %b want %b", c, 1'(od1 + 1'(c >> 1) + 1'(c)), 1'(c >> 2)); end
            n_checks++; if (lat !== 1)
                begin n_fail++; $display("FAIL ex1_latency combo%0d: got %0d want 1", c, lat); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0; x  = '0;   y  = '0;   b_in  = 1'b0;
        start1 = 1'b0; x1 = 1'b0; y1 = 1'b0; b_in1 = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
